load_btn_cond: RTL and testbench

Conditions the two raw active-low push-buttons that drive the load counter. It synchronises and debounces each button, then turns each press into exactly one clean, active-low, fixed-width pulse on `plus` or `minus`. Pulses never overlap and are separated by a guaranteed idle gap, so the downstream edge-triggered up/down load counter sees one edge per physical press. It sits directly between the board pins and the load counter's `plus`/`minus` inputs.

---
 rtl/load_btn_cond.sv | 162 ++++++++++++++++
 tb/tb_load_btn_cond.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_btn_cond.sv
// Push-button conditioner for the load counter: two-stage synchronisers, per-channel
// debouncers, one-deep press latches and a pulse/gap sequencer driving active-low pulses.
module load_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic plus_btn,
    input  logic minus_btn,
    output logic plus,
    output logic minus,
    output logic busy
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);
    localparam logic [PW-1:0] P_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [GW-1:0] G_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] G_ONE   = GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Channel index 0 is plus, index 1 is minus.
    logic [1:0]    btn_s;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    stable_q, stable_d;
    logic [1:0]    stable_dly_q, stable_dly_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];
    logic [1:0]    press_s;
    logic [1:0]    take_s;
    logic [1:0]    pend_q, pend_d;
    state_t        state_q, state_d;
    logic          sel_minus_q, sel_minus_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          plus_q, plus_d;
    logic          minus_q, minus_d;
    logic          busy_q, busy_d;

    assign btn_s = {minus_btn, plus_btn};

    // Synchronise, debounce and detect the released-to-pressed transition per channel.
    always_comb begin
        sync1_d      = btn_s;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
        press_s = stable_dly_q & ~stable_q;
    end

    // Sequencer: serve one latched press, hold the pulse, then enforce the idle gap.
    always_comb begin
        state_d     = state_q;
        sel_minus_d = sel_minus_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        take_s      = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (pend_q[0]) begin
                    take_s      = 2'b01;
                    sel_minus_d = 1'b0;
                    pulse_cnt_d = '0;
                    state_d     = ST_PULSE;
                end else if (pend_q[1]) begin
                    take_s      = 2'b10;
                    sel_minus_d = 1'b1;
                    pulse_cnt_d = '0;
                    state_d     = ST_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (pulse_cnt_q == P_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + P_ONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == G_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + G_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A press arriving while its flag is still set is simply absorbed.
        pend_d  = (pend_q & ~take_s) | press_s;
        plus_d  = !((state_d == ST_PULSE) && !sel_minus_d);
        minus_d = !((state_d == ST_PULSE) && sel_minus_d);
        busy_d  = (state_d != ST_IDLE);
    end

    // State registers; outputs return to idle immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            stable_q     <= 2'b11;
            stable_dly_q <= 2'b11;
            db_cnt_q[0]  <= '0;
            db_cnt_q[1]  <= '0;
            pend_q       <= 2'b00;
            state_q      <= ST_IDLE;
            sel_minus_q  <= 1'b0;
            pulse_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            plus_q       <= 1'b1;
            minus_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            db_cnt_q[0]  <= db_cnt_d[0];
            db_cnt_q[1]  <= db_cnt_d[1];
            pend_q       <= pend_d;
            state_q      <= state_d;
            sel_minus_q  <= sel_minus_d;
            pulse_cnt_q  <= pulse_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            plus_q       <= plus_d;
            minus_q      <= minus_d;
            busy_q       <= busy_d;
        end
    end

    assign plus  = plus_q;
    assign minus = minus_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_load_btn_cond.sv
// Bench for load_btn_cond: directed timing table, hand-written press sequences and a
// randomized run compared against an edge-timeline reference model.
module tb_load_btn_cond;
    localparam int D = 16;
    localparam int P = 4;
    localparam int G = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic plus_btn = 1'b1;
    logic minus_btn = 1'b1;
    logic plus, minus, busy;

    load_btn_cond #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES(P),
        .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .plus_btn(plus_btn),
        .minus_btn(minus_btn),
        .plus(plus),
        .minus(minus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int ecount = 0;

    // Reference model: channel state plus a timeline of when the sequencer is free.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_st [2];
    bit m_fell [2];
    bit m_pend [2];
    int m_run [2];
    int m_next_ok, m_low_end, m_busy_end;
    bit m_sel;

    // Pulse monitor
    int pulses [2];
    int first_low [2];
    int low_len [2];
    bit prev_lvl [2];
    int last_low_e;
    bit have_pulse;
    bit order_q [$];

    typedef struct {
        bit pb; bit mb; int first; int last; bit ep; bit em; bit eb;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    endtask

    task automatic check_min(input string name, input int act, input int min);
        n_checks++;
        if (act >= min) n_pass++;
        else $display("FAIL %s: got %0d expected at least %0d (edge %0d)", name, act, min, ecount);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_st[c] = 1'b1;
            m_fell[c] = 1'b0; m_pend[c] = 1'b0; m_run[c] = 0;
        end
        m_next_ok = 0; m_low_end = -1; m_busy_end = -1; m_sel = 1'b0;
    endfunction

    function automatic void model_edge(input bit pin0, input bit pin1);
        bit take [2];
        bit pins [2];
        bit fell_new;
        pins[0] = pin0; pins[1] = pin1;
        take[0] = 1'b0; take[1] = 1'b0;
        if (ecount >= m_next_ok) begin
            if (m_pend[0]) take[0] = 1'b1;
            else if (m_pend[1]) take[1] = 1'b1;
            if (take[0] || take[1]) begin
                m_sel      = take[1];
                m_low_end  = ecount + P - 1;
                m_busy_end = ecount + P + G - 1;
                m_next_ok  = ecount + P + G + 1;
            end
        end
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = (m_pend[c] && !take[c]) || m_fell[c];
            fell_new = 1'b0;
            if (m_s2[c] != m_st[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    fell_new = (m_s2[c] == 1'b0);
                    m_st[c] = m_s2[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = pins[c];
            m_fell[c] = fell_new;
        end
    endfunction

    function automatic int model_out();
        bit ep, em, eb;
        ep = !(m_sel == 1'b0 && ecount <= m_low_end);
        em = !(m_sel == 1'b1 && ecount <= m_low_end);
        eb = (ecount <= m_busy_end);
        return int'({ep, em, eb});
    endfunction

    function automatic void clear_track();
        for (int c = 0; c < 2; c++) begin
            pulses[c] = 0; first_low[c] = -1; low_len[c] = 0; prev_lvl[c] = 1'b1;
        end
        last_low_e = -1000; have_pulse = 1'b0;
        order_q.delete();
    endfunction

    task automatic observe();
        bit lvl [2];
        lvl[0] = plus; lvl[1] = minus;
        check("model_plus_minus_busy", int'({plus, minus, busy}), model_out());
        check("never_both_low", int'(plus | minus), 1);
        for (int c = 0; c < 2; c++) begin
            if (!lvl[c]) begin
                if (prev_lvl[c]) begin
                    if (have_pulse) check_min("gap_len", ecount - last_low_e - 1, G + 1);
                    pulses[c]++;
                    order_q.push_back(c[0]);
                    if (first_low[c] < 0) first_low[c] = ecount;
                    have_pulse = 1'b1;
                end
                low_len[c]++;
                last_low_e = ecount;
            end else if (!prev_lvl[c]) begin
                check("pulse_len", low_len[c], P);
                low_len[c] = 0;
            end
            prev_lvl[c] = lvl[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        ecount++;
        if (!rst_n) model_reset();
        else model_edge(plus_btn, minus_btn);
        @(negedge clk);
        observe();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_plus", int'(plus), 1);
        check("rst_minus", int'(minus), 1);
        check("rst_busy", int'(busy), 0);
        model_reset();
        clear_track();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        int hold [2];
        bit exp_order [4];
        model_reset();
        clear_track();
        @(negedge clk);
        apply_reset();

        // Idle after reset with both buttons released
        for (int k = 0; k < 100; k++) begin
            tick();
            check("idle_plus", int'(plus), 1);
            check("idle_minus", int'(minus), 1);
            check("idle_busy", int'(busy), 0);
        end

        // Simultaneous press: edge-exact timing table (values seen after each edge)
        tbl[0] = '{1'b0, 1'b0,  0, 18, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 19, 22, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 23, 26, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 27, 27, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 28, 31, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32, 35, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 36, 60, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            for (int e = tbl[i].first; e <= tbl[i].last; e++) begin
                plus_btn = tbl[i].pb;
                minus_btn = tbl[i].mb;
                tick();
                check($sformatf("tbl%0d_plus", i), int'(plus), int'(tbl[i].ep));
                check($sformatf("tbl%0d_minus", i), int'(minus), int'(tbl[i].em));
                check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
            end
        end
        plus_btn = 1'b1; minus_btn = 1'b1;
        for (int k = 0; k < 40; k++) tick();

        // Single clean plus press held 200 cycles, then released
        apply_reset();
        for (int k = 0; k < 5; k++) tick();
        clear_track();
        base = ecount + 1;
        plus_btn = 1'b0;
        for (int k = 0; k < 200; k++) tick();
        plus_btn = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        check("single_plus_count", pulses[0], 1);
        check("single_minus_count", pulses[1], 0);
        check("single_plus_latency", first_low[0] - base, D + 3);

        // Bouncing minus button, then a clean hold
        apply_reset();
        for (int k = 0; k < 5; k++) tick();
        clear_track();
        base = ecount + 1;
        for (int k = 0; k < 60; k++) begin
            minus_btn = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        check("bounce_no_pulse", pulses[1], 0);
        minus_btn = 1'b0;
        for (int k = 0; k < 60; k++) tick();
        minus_btn = 1'b1;
        for (int k = 0; k < 40; k++) tick();
        check("bounce_minus_count", pulses[1], 1);
        check("bounce_minus_latency", first_low[1] - base, 60 + D + 3);
        check("bounce_plus_count", pulses[0], 0);

        // Three plus presses 40 cycles apart, minus pressed during the first pulse
        apply_reset();
        for (int k = 0; k < 5; k++) tick();
        clear_track();
        for (int k = 0; k < 160; k++) begin
            plus_btn = (k < 120 && (k % 40) < 20) ? 1'b0 : 1'b1;
            minus_btn = (k >= 20 && k < 40) ? 1'b0 : 1'b1;
            tick();
        end
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
        check("order_len", order_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < order_q.size()) check($sformatf("order%0d", i), int'(order_q[i]), int'(exp_order[i]));
        end

        // Reset during the second cycle of a plus pulse with minus pending
        apply_reset();
        for (int k = 0; k < 5; k++) tick();
        clear_track();
        plus_btn = 1'b0; minus_btn = 1'b0;
        for (int k = 0; k <= D + 4; k++) tick();
        check("pre_reset_plus_low", int'(plus), 0);
        check("pre_reset_low_cycles", low_len[0], 2);
        plus_btn = 1'b1; minus_btn = 1'b1;
        apply_reset();
        for (int k = 0; k < 100; k++) tick();
        check("post_reset_plus", pulses[0], 0);
        check("post_reset_minus", pulses[1], 0);

        // Randomized buttons against the reference model
        apply_reset();
        clear_track();
        hold[0] = 0; hold[1] = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold[0] == 0) begin
                plus_btn = ~plus_btn;
                hold[0] = int'($urandom_range(1, 45));
            end
            if (hold[1] == 0) begin
                minus_btn = ~minus_btn;
                hold[1] = int'($urandom_range(1, 45));
            end
            hold[0]--; hold[1]--;
            if (k == 1500) apply_reset();
            if (k == 1500) clear_track();
            tick();
        end
        check_min("random_plus_pulses", pulses[0], 1);
        check_min("random_minus_pulses", pulses[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
